branch_prediction_unit: RTL and testbench

//  Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters.

---
 rtl/bpu_pkg.sv | 40 ++++
 rtl/bpu_sat_counter.sv | 21 ++
 rtl/branch_prediction_unit.sv | 140 ++++++++++++++
 tb/tb_branch_prediction_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch prediction unit: counter encodings,
// PC increment and the BTB entry layout.
package bpu_pkg;

  localparam int BPU_XLEN = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  localparam logic [BPU_XLEN-1:0] PC_INC = 32'd4;

  // Tag is stored right-justified and zero-extended to the full address width.
  typedef struct packed {
    logic                valid;
    logic [BPU_XLEN-1:0] tag;
    logic [BPU_XLEN-1:0] target;
    ctr_e                ctr;
    logic                jump;
  } btb_entry_t;

  localparam btb_entry_t BTB_ENTRY_RESET = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_RESET,
    jump:   1'b0
  };

  function automatic logic ctr_predicts_taken(input ctr_e ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/bpu_sat_counter.sv
// Combinational next state of a 2-bit saturating branch counter.
module bpu_sat_counter
  import bpu_pkg::*;
(
  input  logic taken,
  input  ctr_e ctr,
  output ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (ctr)
      SNT: ctr_next = taken ? WNT : SNT;
      WNT: ctr_next = taken ? WT  : SNT;
      WT:  ctr_next = taken ? ST  : WNT;
      ST:  ctr_next = taken ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_prediction_unit.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters, zero-latency
// lookup, single-port training from execute and resolve/mispredict counters.
module branch_prediction_unit
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            prediction_valid,
  output logic [XLEN-1:0] predicted_pc,
  input  logic            branch_resolve,
  input  logic [XLEN-1:0] resolve_pc,
  input  logic            resolve_is_jump,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            flush_fetch,
  output logic [31:0]     resolve_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t btb_rd [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  btb_entry_t       fetch_entry;
  logic             fetch_hit;
  logic [XLEN-1:0]  fetch_pc_inc;

  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  btb_entry_t       res_entry;
  logic             res_hit;
  logic             res_taken;
  ctr_e             res_ctr_next;

  logic             wr_en;
  btb_entry_t       wr_entry_d;

  logic [31:0] resolve_count_q, resolve_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // Lookup: reads the registered entries only, so a same-cycle update is not bypassed.
  assign fetch_idx    = fetch_pc[IDX_W+1:2];
  assign fetch_tag    = fetch_pc[XLEN-1:IDX_W+2];
  assign fetch_entry  = btb_rd[fetch_idx];
  assign fetch_hit    = fetch_entry.valid && (fetch_entry.tag == BPU_XLEN'(fetch_tag));
  assign fetch_pc_inc = fetch_pc + XLEN'(PC_INC);

  always_comb begin
    prediction_valid = 1'b0;
    predicted_pc     = fetch_pc_inc;
    if (!rst && fetch_hit &&
        (fetch_entry.jump || ctr_predicts_taken(fetch_entry.ctr))) begin
      prediction_valid = 1'b1;
      predicted_pc     = XLEN'(fetch_entry.target);
    end
  end

  assign res_idx   = resolve_pc[IDX_W+1:2];
  assign res_tag   = resolve_pc[XLEN-1:IDX_W+2];
  assign res_entry = btb_rd[res_idx];
  assign res_hit   = res_entry.valid && (res_entry.tag == BPU_XLEN'(res_tag));
  assign res_taken = resolve_is_jump | branch_taken;

  bpu_sat_counter u_sat_counter (
    .taken    (res_taken),
    .ctr      (res_entry.ctr),
    .ctr_next (res_ctr_next)
  );

  always_comb begin
    wr_en      = 1'b0;
    wr_entry_d = res_entry;
    if (branch_resolve) begin
      if (res_hit) begin
        wr_en = 1'b1;
        if (resolve_is_jump) begin
          wr_entry_d.ctr    = ST;
          wr_entry_d.jump   = 1'b1;
          wr_entry_d.target = BPU_XLEN'(branch_addr);
        end else if (branch_taken) begin
          wr_entry_d.ctr    = res_ctr_next;
          wr_entry_d.jump   = 1'b0;
          wr_entry_d.target = BPU_XLEN'(branch_addr);
        end else begin
          wr_entry_d.ctr    = res_ctr_next;
        end
      end else if (res_taken) begin
        // Miss on a taken resolve replaces whatever lives at this index.
        wr_en             = 1'b1;
        wr_entry_d.valid  = 1'b1;
        wr_entry_d.tag    = BPU_XLEN'(res_tag);
        wr_entry_d.target = BPU_XLEN'(branch_addr);
        wr_entry_d.ctr    = resolve_is_jump ? ST : CTR_ALLOC;
        wr_entry_d.jump   = resolve_is_jump;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      btb_entry_t entry_q;
      logic       wr_sel;

      assign wr_sel     = wr_en && (res_idx == IDX_W'(gi));
      assign btb_rd[gi] = entry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_q <= BTB_ENTRY_RESET;
        end else if (wr_sel) begin
          entry_q <= wr_entry_d;
        end
      end
    end
  endgenerate

  assign resolve_count_d    = resolve_count_q + {31'd0, branch_resolve};
  assign mispredict_count_d = mispredict_count_q + {31'd0, flush_fetch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolve_count_q    <= '0;
      mispredict_count_q <= '0;
    end else begin
      resolve_count_q    <= resolve_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign resolve_count    = resolve_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_prediction_unit.sv
// Directed and random checks of branch_prediction_unit against a behavioural BTB model.
module tb_branch_prediction_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        prediction_valid;
  logic [31:0] predicted_pc;
  logic        branch_resolve;
  logic [31:0] resolve_pc;
  logic        resolve_is_jump;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        flush_fetch;
  logic [31:0] resolve_count;
  logic [31:0] mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one record per BTB slot, counter kept as a plain integer 0..3.
  logic        m_valid  [16];
  logic [25:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  logic        m_jump   [16];
  logic [31:0] m_res_cnt;
  logic [31:0] m_mis_cnt;

  always #5 clk = ~clk;

  branch_prediction_unit #(.ENTRIES(16), .XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .prediction_valid (prediction_valid),
    .predicted_pc     (predicted_pc),
    .branch_resolve   (branch_resolve),
    .resolve_pc       (resolve_pc),
    .resolve_is_jump  (resolve_is_jump),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .flush_fetch      (flush_fetch),
    .resolve_count    (resolve_count),
    .mispredict_count (mispredict_count)
  );

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i]  = 1'b0;
      m_tag[i]    = '0;
      m_target[i] = '0;
      m_ctr[i]    = 1;
      m_jump[i]   = 1'b0;
    end
    m_res_cnt = '0;
    m_mis_cnt = '0;
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic pv, output logic [31:0] ppc);
    int   i   = int'(pc[5:2]);
    logic hit = m_valid[i] && (m_tag[i] == pc[31:6]);
    pv  = hit && (m_jump[i] || m_ctr[i] >= 2);
    ppc = pv ? m_target[i] : pc + 32'd4;
  endfunction

  function automatic void model_update(input logic [31:0] rpc, input logic jmp, input logic tk,
                                       input logic [31:0] addr);
    int   i     = int'(rpc[5:2]);
    logic hit   = m_valid[i] && (m_tag[i] == rpc[31:6]);
    logic taken = jmp || tk;
    if (hit) begin
      if (jmp) begin
        m_ctr[i] = 3; m_jump[i] = 1'b1; m_target[i] = addr;
      end else if (taken) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_jump[i] = 1'b0; m_target[i] = addr;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (taken) begin
      m_valid[i] = 1'b1; m_tag[i] = rpc[31:6]; m_target[i] = addr;
      m_ctr[i] = jmp ? 3 : 2; m_jump[i] = jmp;
    end
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic        pv;
    logic [31:0] ppc;
    model_predict(fetch_pc, pv, ppc);
    check32({tag, ".pred_valid"}, {31'd0, prediction_valid}, {31'd0, pv});
    check32({tag, ".pred_pc"}, predicted_pc, ppc);
    check32({tag, ".resolve_count"}, resolve_count, m_res_cnt);
    check32({tag, ".mispredict_count"}, mispredict_count, m_mis_cnt);
  endtask

  // One cycle, entered just after a falling edge: drive, check lookup (old contents), clock, update model.
  task automatic cycle(input string tag, input logic [31:0] fpc, input logic res,
                       input logic [31:0] rpc, input logic jmp, input logic tk,
                       input logic [31:0] addr, input logic flush);
    fetch_pc        = fpc;
    branch_resolve  = res;
    resolve_pc      = rpc;
    resolve_is_jump = jmp;
    branch_taken    = tk;
    branch_addr     = addr;
    flush_fetch     = flush;
    #1;
    check_outputs(tag);
    $display("[TB] %s fetch=%08h pv=%0b ppc=%08h res=%0b rpc=%08h j=%0b t=%0b addr=%08h fl=%0b",
             tag, fpc, prediction_valid, predicted_pc, res, rpc, jmp, tk, addr, flush);
    @(posedge clk);
    if (res) begin
      model_update(rpc, jmp, tk, addr);
      m_res_cnt = m_res_cnt + 32'd1;
    end
    if (flush) m_mis_cnt = m_mis_cnt + 32'd1;
    @(negedge clk);
  endtask

  task automatic lookup(input string tag, input logic [31:0] fpc);
    cycle(tag, fpc, 1'b0, $urandom, 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = ({30'd0, 2'($urandom_range(0, 3))} << 6) | ({28'd0, 4'($urandom_range(0, 15))} << 2)
       | {30'd0, 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 9) == 0) pc = pc | ($urandom & 32'hFFFF_FF00);
    return pc;
  endfunction

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h100; branch_resolve = 1'b0; resolve_pc = '0; resolve_is_jump = 1'b0;
    branch_taken = 1'b0; branch_addr = '0; flush_fetch = 1'b0;
    model_reset();
    #2;
    check32("reset.pred_valid", {31'd0, prediction_valid}, 32'd0);
    check32("reset.pred_pc", predicted_pc, 32'h104);
    check32("reset.resolve_count", resolve_count, 32'd0);
    check32("reset.mispredict_count", mispredict_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    cycle("alloc_same_cycle", 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    lookup("alloc_visible", 32'h100);
    check32("alloc_target", predicted_pc, 32'h80);

    cycle("dec_1", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    lookup("after_dec_1", 32'h100);
    cycle("dec_2", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("dec_3", 32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle("inc_from_snt", 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    lookup("no_underflow", 32'h100);
    cycle("inc_again", 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
    lookup("taken_again", 32'h100);

    lookup("alias_miss", 32'h140);
    cycle("alias_alloc", 32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0);
    lookup("alias_old_gone", 32'h100);
    lookup("alias_new_hit", 32'h140);

    cycle("jal_alloc", 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 32'h400, 1'b0);
    lookup("jal_hit", 32'h200);
    cycle("jal_again", 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 32'h400, 1'b0);
    lookup("jal_still_taken", 32'h200);
    lookup("pc_wrap", 32'hFFFF_FFFC);

    // Asynchronous reset between edges clears state without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    check32("async_rst.pred_valid", {31'd0, prediction_valid}, 32'd0);
    check32("async_rst.pred_pc", predicted_pc, fetch_pc + 32'd4);
    check32("async_rst.resolve_count", resolve_count, 32'd0);
    check32("async_rst.mispredict_count", mispredict_count, 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    @(negedge clk);
    lookup("post_rst_jal_gone", 32'h200);

    for (int k = 0; k < 5; k++)
      cycle("perf", 32'h500, 1'b1, 32'h600 + 32'(k * 4), 1'b0, 1'(k % 2), 32'h700, 1'(k < 2));
    check32("perf.resolve_count_5", resolve_count, 32'd5);
    check32("perf.mispredict_count_2", mispredict_count, 32'd2);

    force dut.resolve_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.resolve_count_q;
    m_res_cnt = 32'hFFFF_FFFF;
    cycle("cnt_wrap", 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
    check32("cnt_wrap.zero", resolve_count, 32'd0);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] rpc;
      rpc = rand_pc();
      cycle("rand", ($urandom_range(0, 1) == 0) ? rpc : rand_pc(), 1'($urandom_range(0, 2) != 0),
            rpc, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
